// File: rtl/oam_dma_pkg.sv
// -----------------------------------------------------------------------------
// oam_dma_pkg
// Shared definitions for the OAM sprite DMA engine:
//   - dma_state_t   : DMA controller states
//   - OAM_DATA_ADDR : PPU OAM data port, the destination of every DMA write
//   - DMA_PAGE_REG  : CPU register whose write launches a transfer
//   - REG_WIDTH / ADDR_WIDTH : CPU register and bus address widths
// The optional alignment cycle is enabled with the macro OAM_DMA_ALIGN_EN.
// -----------------------------------------------------------------------------
package oam_dma_pkg;

    localparam int REG_WIDTH  = 8;
    localparam int ADDR_WIDTH = 16;

    localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;
    localparam logic [15:0] DMA_PAGE_REG  = 16'h4014;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        ALIGN = 3'd2,
        READ  = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } dma_state_t;

    // Address decode helper for the top-level glue: a CPU write to the page
    // register is what produces the one-cycle start pulse for this block.
    function automatic logic dma_trigger(input logic [ADDR_WIDTH-1:0] addr,
                                         input logic                  we);
        return we && (addr == DMA_PAGE_REG);
    endfunction

endpackage

// File: rtl/oam_dma_if.sv
// -----------------------------------------------------------------------------
// oam_dma_if
// Single-port memory bus shared by the CPU and the OAM DMA engine.
//   mem_addr  : bus address          (initiator -> memory)
//   mem_wdata : write data           (initiator -> memory)
//   mem_we    : write enable         (initiator -> memory)
//   mem_rdata : read data, combinational from memory when mem_we=0
// Modports: master = bus initiator (DMA), slave = memory side.
// -----------------------------------------------------------------------------
interface oam_dma_if #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 16
) ();

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0]      mem_wdata;
    logic [WIDTH-1:0]      mem_rdata;
    logic                  mem_we;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_we,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_we,
        output mem_rdata
    );

endinterface

// File: rtl/oam_dma.sv
// -----------------------------------------------------------------------------
// oam_dma
// NES-style $4014 sprite DMA: copies one page (LENGTH bytes) from CPU memory
// to the fixed OAM data port, one read followed by one write per byte.
//
// Ports:
//   clk      : system clock, rising edge
//   reset    : asynchronous, active-high; aborts any transfer in flight
//   start    : one-cycle pulse, begin a transfer (ignored while busy)
//   page     : source page, source address = {page, idx}
//   busy     : DMA owns the bus
//   cpu_rdy  : low while the CPU is stalled
//   done     : one-cycle pulse after the last write
//   bus      : memory bus (master modport): mem_addr, mem_wdata, mem_we, mem_rdata
//
// Build option: define OAM_DMA_ALIGN_EN to insert one ALIGN cycle after HALT
// whenever the free-running parity flop is 1 (odd-cycle DMA start on the NES).
// -----------------------------------------------------------------------------
module oam_dma
    import oam_dma_pkg::*;
#(
    parameter int                    WIDTH      = oam_dma_pkg::REG_WIDTH,
    parameter int                    ADDR_WIDTH = oam_dma_pkg::ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] DEST_ADDR  = ADDR_WIDTH'(oam_dma_pkg::OAM_DATA_ADDR),
    parameter int                    LENGTH     = 256
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [7:0]      page,
    output logic            busy,
    output logic            cpu_rdy,
    output logic            done,
    oam_dma_if.master       bus
);

    localparam logic [7:0] LAST_IDX = 8'(LENGTH - 1);

    dma_state_t            state;
    logic [7:0]            page_q;
    logic [7:0]            idx;
    logic [WIDTH-1:0]      data_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;

    // Source address of the byte currently indexed.
    logic [ADDR_WIDTH-1:0] src_addr;
    // Source address of the byte after it, loaded when WRITE loops to READ.
    logic [ADDR_WIDTH-1:0] next_src_addr;

    assign src_addr      = ADDR_WIDTH'({page_q, idx});
    assign next_src_addr = ADDR_WIDTH'({page_q, idx + 8'd1});

`ifdef OAM_DMA_ALIGN_EN
    // Free-running even/odd cycle marker; only reset clears it.
    logic parity;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity <= 1'b0;
        end else begin
            parity <= ~parity;
        end
    end
`endif

    // Every output is registered: the value visible during a state is loaded
    // on the edge that enters it, so the memory sees a stable address, data
    // and write enable for the whole WRITE cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            cpu_rdy <= 1'b1;
            done    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            idx     <= 8'd0;
            page_q  <= 8'd0;
        end else begin
            done <= 1'b0;
            we_q <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        page_q  <= page;
                        idx     <= 8'd0;
                        busy    <= 1'b1;
                        cpu_rdy <= 1'b0;
                        state   <= HALT;
                    end
                end

                HALT: begin
`ifdef OAM_DMA_ALIGN_EN
                    if (parity) begin
                        state <= ALIGN;
                    end else begin
                        addr_q <= src_addr;
                        state  <= READ;
                    end
`else
                    addr_q <= src_addr;
                    state  <= READ;
`endif
                end

`ifdef OAM_DMA_ALIGN_EN
                ALIGN: begin
                    addr_q <= src_addr;
                    state  <= READ;
                end
`endif

                READ: begin
                    // Memory read data is combinational on addr_q; capture it
                    // on the way out of READ and present it as write data.
                    data_q <= bus.mem_rdata;
                    addr_q <= DEST_ADDR;
                    we_q   <= 1'b1;
                    state  <= WRITE;
                end

                WRITE: begin
                    idx <= idx + 8'd1;
                    if (idx == LAST_IDX) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        addr_q <= next_src_addr;
                        state  <= READ;
                    end
                end

                DONE: begin
                    busy    <= 1'b0;
                    cpu_rdy <= 1'b1;
                    state   <= IDLE;
                end

                default: begin
                    busy    <= 1'b0;
                    cpu_rdy <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = data_q;
    assign bus.mem_we    = we_q;

endmodule
